// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, bus width and error-sequencing states for the master.
package ahb_lite_master_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ERR_NORMAL = 2'd0;
  localparam logic [1:0] ERR_ERR2   = 2'd1;
  localparam logic [1:0] ERR_CANCEL = 2'd2;

  // Anything wider than the bus is issued as a full word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > HSIZE_WORD) ? HSIZE_WORD : size;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Pipelined single-transfer AHB-Lite master: one address phase overlapped with one data phase.
// Responses return in command order; a two-cycle ERROR cancels the queued address phase.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [BUS_WIDTH-1:0]  HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [BUS_WIDTH-1:0]  HRDATA
);

  logic [1:0]            err_state;
  logic                  cancel_pend;
  logic                  dp_valid;
  logic                  dp_write;
  logic [BUS_WIDTH-1:0]  ap_wdata;
  logic                  cmd_fire;
  logic                  dp_done;
  logic                  err_first;
  logic [2:0]            size_c;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_comb begin
    cmd_ready = HRESETn & HREADY & (err_state == ERR_NORMAL);
    cmd_fire  = cmd_valid & cmd_ready;
    dp_done   = dp_valid & HREADY;
    err_first = (err_state == ERR_NORMAL) & dp_valid & ~HREADY & (HRESP == HRESP_ERROR);
    size_c    = clamp_size(cmd_size);
    addr_c    = cmd_addr;
    case (size_c)
      HSIZE_WORD: addr_c[1:0] = 2'b00;
      HSIZE_HALF: addr_c[0]   = 1'b0;
      default:    ;
    endcase
  end

  // Address phase: only moves on HREADY, except the ERROR cancel which must drop NONSEQ early.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HTRANS   <= HTRANS_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= HSIZE_BYTE;
      ap_wdata <= '0;
    end else if (HREADY) begin
      if (cmd_fire) begin
        HTRANS   <= HTRANS_NONSEQ;
        HADDR    <= addr_c;
        HWRITE   <= cmd_write;
        HSIZE    <= size_c;
        ap_wdata <= cmd_wdata;
      end else begin
        HTRANS <= HTRANS_IDLE;
      end
    end else if (err_first) begin
      HTRANS <= HTRANS_IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      HWDATA   <= '0;
    end else if (HREADY) begin
      dp_valid <= (HTRANS == HTRANS_NONSEQ);
      if (HTRANS == HTRANS_NONSEQ) begin
        dp_write <= HWRITE;
        HWDATA   <= HWRITE ? ap_wdata : '0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_done | (err_state == ERR_CANCEL);
      rsp_err   <= (dp_done & (HRESP == HRESP_ERROR)) | (err_state == ERR_CANCEL);
      rsp_rdata <= (dp_done & ~dp_write & (HRESP == HRESP_OKAY)) ? HRDATA : '0;
    end
  end

  // A cancelled address phase owes its own error response, emitted right after the failed one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_state   <= ERR_NORMAL;
      cancel_pend <= 1'b0;
    end else begin
      case (err_state)
        ERR_NORMAL: begin
          if (err_first) begin
            err_state   <= ERR_ERR2;
            cancel_pend <= (HTRANS == HTRANS_NONSEQ);
          end
        end
        ERR_ERR2: begin
          if (dp_done) err_state <= cancel_pend ? ERR_CANCEL : ERR_NORMAL;
        end
        ERR_CANCEL: begin
          err_state   <= ERR_NORMAL;
          cancel_pend <= 1'b0;
        end
        default: err_state <= ERR_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: cycle-by-cycle vector table plus reset-in-flight sequence.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.ADDR_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    logic        cv, cw;
    logic [31:0] ca;
    logic [2:0]  cs;
    logic [31:0] cd;
    logic        rdy, rsp;
    logic [31:0] rdat;
    logic        e_crdy;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [2:0]  e_size;
    logic [31:0] e_wdata;
    logic        e_rv, e_rerr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic cv, input logic cw, input logic [31:0] ca,
                             input logic [2:0] cs, input logic [31:0] cd,
                             input logic rdy, input logic rsp, input logic [31:0] rdat,
                             input logic e_crdy, input logic [1:0] e_trans,
                             input logic [31:0] e_addr, input logic e_wr,
                             input logic [2:0] e_size, input logic [31:0] e_wdata,
                             input logic e_rv, input logic e_rerr, input logic [31:0] e_rdata);
    vec_t r;
    r.cv = cv; r.cw = cw; r.ca = ca; r.cs = cs; r.cd = cd;
    r.rdy = rdy; r.rsp = rsp; r.rdat = rdat;
    r.e_crdy = e_crdy; r.e_trans = e_trans; r.e_addr = e_addr; r.e_wr = e_wr;
    r.e_size = e_size; r.e_wdata = e_wdata;
    r.e_rv = e_rv; r.e_rerr = e_rerr; r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic cw, input logic [31:0] ca, input logic [2:0] cs,
                       input logic [31:0] cd, input logic rdy, input logic rsp, input logic [31:0] rdat);
    cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_size = cs; cmd_wdata = cd;
    HREADY = rdy; HRESP = rsp; HRDATA = rdat;
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // write/read, alignment and clamping
    vecs.push_back(v(1,1,'h0, 2,'hffddccaa, 1,0,0,           1,0,'h0, 0,0,0,           0,0,0));
    vecs.push_back(v(1,0,'h0, 2,0,          1,0,0,           1,2,'h0, 1,2,0,           0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,2,'h0, 0,2,'hffddccaa,  0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,'hffddccaa,  1,0,'h0, 0,2,0,           1,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h0, 0,2,0,           1,0,'hffddccaa));
    vecs.push_back(v(1,0,'ha, 2,0,          1,0,0,           1,0,'h0, 0,2,0,           0,0,0));
    vecs.push_back(v(1,0,'h7, 1,0,          1,0,0,           1,2,'h8, 0,2,0,           0,0,0));
    vecs.push_back(v(1,1,'h13,7,'h12345678, 1,0,'haaaa5555,  1,2,'h6, 0,1,0,           0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,'h00bb0000,  1,2,'h10,1,2,0,           1,0,'haaaa5555));
    vecs.push_back(v(0,0,0,   0,0,          1,0,'hdeadbeef,  1,0,'h10,1,2,'h12345678,  1,0,'h00bb0000));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h10,1,2,'h12345678,  1,0,0));
    // back-to-back writes
    vecs.push_back(v(1,1,'h0, 2,'h11111111, 1,0,0,           1,0,'h10,1,2,'h12345678,  0,0,0));
    vecs.push_back(v(1,1,'h4, 2,'h22222222, 1,0,0,           1,2,'h0, 1,2,'h12345678,  0,0,0));
    vecs.push_back(v(1,1,'h8, 2,'h33333333, 1,0,0,           1,2,'h4, 1,2,'h11111111,  0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,2,'h8, 1,2,'h22222222,  1,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h8, 1,2,'h33333333,  1,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h8, 1,2,'h33333333,  1,0,0));
    // wait states during a read data phase
    vecs.push_back(v(1,0,'hc, 2,0,          1,0,0,           1,0,'h8, 1,2,'h33333333,  0,0,0));
    vecs.push_back(v(1,1,'h20,2,'h55,       1,0,0,           1,2,'hc, 0,2,'h33333333,  0,0,0));
    vecs.push_back(v(1,0,'h40,2,0,          0,0,0,           0,2,'h20,1,2,0,           0,0,0));
    vecs.push_back(v(1,0,'h40,2,0,          0,0,0,           0,2,'h20,1,2,0,           0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,'hcafef00d,  1,2,'h20,1,2,0,           0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h20,1,2,'h55,        1,0,'hcafef00d));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h20,1,2,'h55,        1,0,0));
    // two-cycle ERROR on write 0x0 while read 0x4 sits in its address phase
    vecs.push_back(v(1,1,'h0, 2,'h99,       1,0,0,           1,0,'h20,1,2,'h55,        0,0,0));
    vecs.push_back(v(1,0,'h4, 2,0,          1,0,0,           1,2,'h0, 1,2,'h55,        0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          0,1,0,           0,2,'h4, 0,2,'h99,        0,0,0));
    vecs.push_back(v(0,0,0,   0,0,          1,1,0,           0,0,'h4, 0,2,'h99,        0,0,0));
    vecs.push_back(v(1,0,'h8, 2,0,          1,0,0,           0,0,'h4, 0,2,'h99,        1,1,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h4, 0,2,'h99,        1,1,0));
    vecs.push_back(v(0,0,0,   0,0,          1,0,0,           1,0,'h4, 0,2,'h99,        0,0,0));

    repeat (2) @(negedge HCLK);
    #1;
    chk("reset_htrans", HTRANS, 0);
    chk("reset_haddr", HADDR, 0);
    chk("reset_hwrite", HWRITE, 0);
    chk("reset_hsize", HSIZE, 0);
    chk("reset_hwdata", HWDATA, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge HCLK);
      drive(vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cs, vecs[i].cd,
            vecs[i].rdy, vecs[i].rsp, vecs[i].rdat);
      #1;
      chk($sformatf("r%0d_cmd_ready", i), cmd_ready, vecs[i].e_crdy);
      chk($sformatf("r%0d_htrans", i), HTRANS, vecs[i].e_trans);
      chk($sformatf("r%0d_haddr", i), HADDR, vecs[i].e_addr);
      chk($sformatf("r%0d_hwrite", i), HWRITE, vecs[i].e_wr);
      chk($sformatf("r%0d_hsize", i), HSIZE, vecs[i].e_size);
      chk($sformatf("r%0d_hwdata", i), HWDATA, vecs[i].e_wdata);
      chk($sformatf("r%0d_rsp_valid", i), rsp_valid, vecs[i].e_rv);
      chk($sformatf("r%0d_rsp_err", i), rsp_err, vecs[i].e_rerr);
      chk($sformatf("r%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
      chk($sformatf("r%0d_hburst", i), HBURST, 0);
      chk($sformatf("r%0d_hprot", i), HPROT, 4'b0011);
      chk($sformatf("r%0d_hmastlock", i), HMASTLOCK, 0);
    end

    // reset asserted while a read data phase is stalled
    @(negedge HCLK);
    drive(1, 0, 'h30, 2, 0, 1, 0, 0);
    #1 chk("rst_seq_accept", cmd_ready, 1);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("rst_seq_nonseq", HTRANS, 2);
    chk("rst_seq_haddr", HADDR, 'h30);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 0, 0, 'h12121212);
    #1 chk("rst_seq_stall_rv", rsp_valid, 0);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_htrans", HTRANS, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    chk("rst_mid_haddr", HADDR, 0);
    @(negedge HCLK);
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      #1;
      chk($sformatf("post_rst%0d_rsp_valid", k), rsp_valid, 0);
      chk($sformatf("post_rst%0d_htrans", k), HTRANS, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
